risc_dmem_responder: RTL



---
 rtl/risc_dmem_responder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/risc_dmem_responder.sv
// Data-memory responder for the 16-bit RISC core: serves valid/ready load/store
// requests from an internal word RAM after a fixed number of wait states.
module risc_dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_rdata,
    output logic              rsp_is_write,
    output logic [CNT_W-1:0]  txn_count
);

    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t             state_q;
    logic [3:0]         waitCount_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [15:0]        wdata_q;
    logic               reqReady_q;
    logic               rspValid_q;
    logic [15:0]        rspRdata_q;
    logic               rspIsWrite_q;
    logic [CNT_W-1:0]   txnCount_q;
    logic [CNT_W-1:0]   txnCount_d;

    logic [15:0]        mem [2**ADDR_W];

    logic               enterResp;
    logic               opWe;
    logic [ADDR_W-1:0]  opAddr;
    logic [15:0]        opWdata;

    // With zero wait states the RAM access happens on the accept edge itself,
    // so the live request is used instead of the captured copy.
    always_comb begin
        enterResp = 1'b0;
        opWe      = we_q;
        opAddr    = addr_q;
        opWdata   = wdata_q;
        if (state_q == IDLE) begin
            opWe      = req_we;
            opAddr    = req_addr;
            opWdata   = req_wdata;
            enterResp = req_valid && (WAIT_CYCLES == 0);
        end else if (state_q == WAIT) begin
            enterResp = (waitCount_q == 4'd0);
        end
        txnCount_d = txnCount_q + CNT_W'(1);
    end

    // RAM is deliberately not reset; a reset during WAIT never reaches enterResp.
    always_ff @(posedge clk) begin
        if (enterResp && opWe) begin
            mem[opAddr] <= opWdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            waitCount_q  <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 16'h0000;
            reqReady_q   <= 1'b1;
            rspValid_q   <= 1'b0;
            rspRdata_q   <= 16'h0000;
            rspIsWrite_q <= 1'b0;
            txnCount_q   <= '0;
        end else begin
            if (enterResp) begin
                rspValid_q   <= 1'b1;
                rspIsWrite_q <= opWe;
                rspRdata_q   <= opWe ? 16'h0000 : mem[opAddr];
            end
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        reqReady_q <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= RESP;
                        end else begin
                            state_q     <= WAIT;
                            waitCount_q <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (waitCount_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        waitCount_q <= waitCount_q - 4'd1;
                    end
                end
                RESP: begin
                    // Ready is only raised after the handshake edge, so no
                    // accept can coincide with a completing response.
                    if (rsp_ready) begin
                        rspValid_q <= 1'b0;
                        txnCount_q <= txnCount_d;
                        reqReady_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    reqReady_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready    = reqReady_q;
    assign rsp_valid    = rspValid_q;
    assign rsp_rdata    = rspRdata_q;
    assign rsp_is_write = rspIsWrite_q;
    assign txn_count    = txnCount_q;

endmodule
